// File: rtl/bootrom_copier_pkg.sv
// Shared types and target-config constants for the boot image copy engine.
package bootcopy_pkg;
  localparam int CFG_BOOTROM_LOG2_SIZE = 16;
  localparam int CFG_SRAM_LOG2_SIZE    = 18;
  localparam int BOOTCOPY_WORD_BYTES   = 8;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} bootcopy_state_t;
endpackage

// File: rtl/bootrom_copier_if.sv
// ROM read port, SRAM write port and boot status of the copy engine.
interface bootrom_copier_if #(
  parameter int abits_rom  = 16,
  parameter int abits_sram = 18
);
  logic                  bypass;
  logic                  rom_req;
  logic [abits_rom-1:0]  rom_addr;
  logic [63:0]           rom_rdata;
  logic                  sram_wvalid;
  logic                  sram_wready;
  logic [abits_sram-1:0] sram_waddr;
  logic [63:0]           sram_wdata;
  logic [7:0]            sram_wstrb;
  logic                  busy;
  logic                  done;
  logic                  cpu_nrst;

  modport master (
    input  bypass, rom_rdata, sram_wready,
    output rom_req, rom_addr, sram_wvalid, sram_waddr, sram_wdata, sram_wstrb,
           busy, done, cpu_nrst
  );

  modport slave (
    output bypass, rom_rdata, sram_wready,
    input  rom_req, rom_addr, sram_wvalid, sram_waddr, sram_wdata, sram_wstrb,
           busy, done, cpu_nrst
  );
endinterface

// File: rtl/bootrom_copier.sv
// Copies copy_words 64-bit words from Boot ROM to SRAM after reset, then
// releases the CPU cluster reset. All outputs are Moore-decoded.
module bootrom_copier
  import bootcopy_pkg::*;
#(
  parameter int abits_rom  = CFG_BOOTROM_LOG2_SIZE,
  parameter int abits_sram = CFG_SRAM_LOG2_SIZE,
  parameter int copy_words = 8192,
  parameter int sram_base  = 0
) (
  input logic i_clk,
  input logic i_nrst,
  bootrom_copier_if.master bus
);
  localparam int CW = (copy_words > 1) ? $clog2(copy_words) : 1;
  localparam int SH = $clog2(BOOTCOPY_WORD_BYTES);
  localparam logic [CW-1:0] LAST = CW'(copy_words - 1);

  if (copy_words == 0) begin : g_bad_len
    $error("bootrom_copier: copy_words must be nonzero");
  end
  if (longint'(copy_words) * BOOTCOPY_WORD_BYTES > (longint'(1) << abits_rom)) begin : g_bad_rom
    $error("bootrom_copier: image larger than Boot ROM");
  end
  if (longint'(sram_base) + longint'(copy_words) * BOOTCOPY_WORD_BYTES
      > (longint'(1) << abits_sram)) begin : g_bad_sram
    $error("bootrom_copier: image does not fit in SRAM");
  end
  if (sram_base % BOOTCOPY_WORD_BYTES != 0) begin : g_bad_base
    $error("bootrom_copier: sram_base must be 8-byte aligned");
  end

  bootcopy_state_t state, state_nx;
  logic [CW-1:0]   cnt;
  logic [63:0]     wdata_r;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      wdata_r <= '0;
    end else begin
      state <= state_nx;
      if (state == WAIT) wdata_r <= bus.rom_rdata;
      // The last word exits to DONE without bumping, so cnt never wraps.
      if (state == WRITE && bus.sram_wready && cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx        = state;
    bus.rom_req     = 1'b0;
    bus.sram_wvalid = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.cpu_nrst    = 1'b0;
    unique case (state)
      IDLE:  state_nx = bus.bypass ? DONE : READ;
      READ: begin
        bus.rom_req = 1'b1;
        bus.busy    = 1'b1;
        state_nx    = WAIT;
      end
      WAIT: begin
        bus.busy = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        bus.sram_wvalid = 1'b1;
        bus.busy        = 1'b1;
        if (bus.sram_wready) state_nx = (cnt == LAST) ? DONE : READ;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.cpu_nrst = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.rom_addr   = abits_rom'(cnt) << SH;
  assign bus.sram_waddr = abits_sram'(sram_base) + (abits_sram'(cnt) << SH);
  assign bus.sram_wdata = wdata_r;
  assign bus.sram_wstrb = {8{bus.sram_wvalid}};
endmodule

// File: tb/tb_bootrom_copier.sv
// Directed and randomized checks of bootrom_copier against a transaction-level model.
module tb_bootrom_copier;
  logic clk = 1'b0;
  logic nrst;
  logic bypass;
  logic wready;
  bit   sel;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] rom_mem [0:7];
  int          stall   [0:7];

  always #5 clk = ~clk;

  bootrom_copier_if #(.abits_rom(16), .abits_sram(18)) ia ();
  bootrom_copier_if #(.abits_rom(16), .abits_sram(18)) ib ();

  bootrom_copier #(.abits_rom(16), .abits_sram(18), .copy_words(4), .sram_base(0))
    dut_a (.i_clk(clk), .i_nrst(nrst), .bus(ia.master));
  bootrom_copier #(.abits_rom(16), .abits_sram(18), .copy_words(1), .sram_base(32'h100))
    dut_b (.i_clk(clk), .i_nrst(nrst), .bus(ib.master));

  assign ia.bypass = bypass;
  assign ib.bypass = bypass;
  assign ia.sram_wready = wready;
  assign ib.sram_wready = wready;

  // ROM: data for the requested word appears one cycle after the strobe.
  always @(posedge clk) if (ia.rom_req) ia.rom_rdata <= rom_mem[ia.rom_addr[5:3]];
  always @(posedge clk) if (ib.rom_req) ib.rom_rdata <= rom_mem[ib.rom_addr[5:3]];

  logic        o_req, o_wvalid, o_busy, o_done, o_cpu;
  logic [31:0] o_raddr, o_waddr;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  assign o_req    = sel ? ib.rom_req     : ia.rom_req;
  assign o_wvalid = sel ? ib.sram_wvalid : ia.sram_wvalid;
  assign o_busy   = sel ? ib.busy        : ia.busy;
  assign o_done   = sel ? ib.done        : ia.done;
  assign o_cpu    = sel ? ib.cpu_nrst    : ia.cpu_nrst;
  assign o_raddr  = sel ? 32'(ib.rom_addr)   : 32'(ia.rom_addr);
  assign o_waddr  = sel ? 32'(ib.sram_waddr) : 32'(ia.sram_waddr);
  assign o_wdata  = sel ? ib.sram_wdata  : ia.sram_wdata;
  assign o_wstrb  = sel ? ib.sram_wstrb  : ia.sram_wstrb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int base);
    chk("rst_rom_req", 64'(o_req), 64'(0));
    chk("rst_rom_addr", 64'(o_raddr), 64'(0));
    chk("rst_wvalid", 64'(o_wvalid), 64'(0));
    chk("rst_waddr", 64'(o_waddr), 64'(base));
    chk("rst_wdata", o_wdata, 64'(0));
    chk("rst_wstrb", 64'(o_wstrb), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_cpu_nrst", 64'(o_cpu), 64'(0));
  endtask

  // Releases reset and follows one boot: expected writes are word k of the ROM
  // to base+8k, and DONE lands at edge 3N plus the planned stall cycles.
  task automatic run_copy(input bit s, input int n, input int base, input bit byp,
                          input int abort_w);
    int e, t, rd, wr, bsy, st;
    t = 0;
    if (!byp) begin
      t = 3 * n;
      for (int k = 0; k < n; k++) t += stall[k];
    end
    sel = s; bypass = byp; wready = 1'b1;
    rd = 0; wr = 0; bsy = 0; st = 0; e = -1;
    nrst = 1'b1;
    while (e < t + 2) begin
      tick();
      e++;
      chk("done", 64'(o_done), 64'(e >= t));
      chk("cpu_nrst", 64'(o_cpu), 64'(e >= t));
      chk("wstrb", 64'(o_wstrb), o_wvalid ? 64'hFF : 64'h0);
      if (o_busy) bsy++;
      if (o_req) begin
        chk("rom_addr", 64'(o_raddr), 64'(8 * rd));
        rd++;
      end
      if (o_wvalid) begin
        chk("waddr", 64'(o_waddr), 64'(base + 8 * wr));
        chk("wdata", o_wdata, rom_mem[wr]);
        if (wr == abort_w) begin
          nrst = 1'b0;
          tick(); chk_reset(base);
          tick(); chk_reset(base);
          return;
        end
        if (st < stall[wr]) begin
          wready = 1'b0; st++;
        end else begin
          wready = 1'b1; wr++; st = 0;
        end
      end else begin
        wready = 1'b1;
      end
    end
    chk("rom_reads", 64'(rd), byp ? 64'(0) : 64'(n));
    chk("sram_writes", 64'(wr), byp ? 64'(0) : 64'(n));
    chk("busy_cycles", 64'(bsy), 64'(t));
    nrst = 1'b0; bypass = 1'b0; wready = 1'b1;
    tick();
  endtask

  initial begin
    nrst = 1'b0; bypass = 1'b0; wready = 1'b1; sel = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rom_mem[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
      stall[k] = 0;
    end
    tick(); tick(); tick();
    sel = 1'b0; #1; chk_reset(0);
    sel = 1'b1; #1; chk_reset(32'h100);

    // plain copy, done after E12
    run_copy(1'b0, 4, 0, 1'b0, -1);

    // 5-cycle stall on word 2, done after E17
    stall[2] = 5;
    run_copy(1'b0, 4, 0, 1'b0, -1);
    stall[2] = 0;

    // bypass: done after E0, no traffic
    run_copy(1'b0, 4, 0, 1'b1, -1);

    // reset during word 2 WRITE, then a clean restart from word 0
    stall[2] = 3;
    run_copy(1'b0, 4, 0, 1'b0, 2);
    stall[2] = 0;
    run_copy(1'b0, 4, 0, 1'b0, -1);

    // random data and random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        rom_mem[k] = {$urandom, $urandom};
        stall[k] = int'($urandom_range(0, 3));
      end
      run_copy(1'b0, 4, 0, 1'b0, -1);
    end

    // single word at offset 0x100
    for (int k = 0; k < 8; k++) stall[k] = 0;
    rom_mem[0] = {$urandom, $urandom};
    run_copy(1'b1, 1, 32'h100, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bootrom_copier.md
# bootrom_copier

Post-reset copy engine that streams the boot image from the internal Boot ROM into the internal SRAM block, then releases the CPU cluster from reset. It sits between the target configuration (ROM and SRAM sizes) and the processor reset tree: the ROM and SRAM are sized by the target config, and this block is the first consumer of both after power-up. Transfers are 64-bit words on a fixed-latency ROM read port and a valid/ready SRAM write port.

## Interface
- Reset: one clock; reset is synchronous and active-low.

**Parameters**
- `abits_rom`, default 16 (`CFG_BOOTROM_LOG2_SIZE`): ROM byte-address width.
- `abits_sram`, default 18 (`CFG_SRAM_LOG2_SIZE`): SRAM byte-address width.
- `copy_words`, default 8192: number of 64-bit words copied. Elaboration error if `copy_words*8 > 2**abits_rom`, if `sram_base + copy_words*8 > 2**abits_sram`, or if `copy_words == 0`.
- `sram_base`, default 0: SRAM destination byte offset. Must be 8-byte aligned; elaboration error otherwise.

**Ports**
- `i_clk`, in, 1: clock.
- `i_nrst`, in, 1: synchronous active-low reset.
- `i_bypass`, in, 1: skip the copy; sampled only in IDLE.
- `o_rom_req`, out, 1: ROM read strobe.
- `o_rom_addr`, out, `abits_rom`: ROM byte address, 8-byte aligned.
- `i_rom_rdata`, in, 64: ROM data, valid exactly 1 cycle after `o_rom_req`. The ROM is always ready.
- `o_sram_wvalid`, out, 1: write request.
- `i_sram_wready`, in, 1: write accepted when high together with `o_sram_wvalid`.
- `o_sram_waddr`, out, `abits_sram`: SRAM byte address.
- `o_sram_wdata`, out, 64: write data.
- `o_sram_wstrb`, out, 8: byte strobes. Driven 0xFF while `o_sram_wvalid` is high, otherwise 0.
- `o_busy`, out, 1: copy in progress.
- `o_done`, out, 1: copy finished or bypassed.
- `o_cpu_nrst`, out, 1: CPU reset. Held low until DONE, then high.

## Operation
- **States:** IDLE, READ, WAIT, WRITE, DONE. Reset forces IDLE, word counter `cnt=0` and data register `wdata_r=0`.
- **IDLE:** if `i_bypass=1`, go to DONE. Otherwise go to READ.
- **READ:** `o_rom_req=1` and `o_rom_addr=cnt*8`. Next state is WAIT.
- **WAIT:** capture `i_rom_rdata` into `wdata_r`. Next state is WRITE.
- **WRITE:**
  - Drive `o_sram_wvalid=1`, `o_sram_waddr=sram_base+cnt*8` and `o_sram_wdata=wdata_r`.
  - If `i_sram_wready=0`, stay in WRITE with all outputs held stable.
  - If `i_sram_wready=1` and `cnt==copy_words-1`, go to DONE.
  - If `i_sram_wready=1` and `cnt<copy_words-1`, increment `cnt` and go to READ.
- **DONE:** `o_done=1` and `o_cpu_nrst=1`. This state is terminal until reset.
- **Output decode:** all outputs are Moore outputs decoded from the state register, `cnt` and `wdata_r`. There is no combinational path from any input to any output.
- **Outputs by state:**
  - `o_busy=1` in READ, WAIT and WRITE.
  - `o_rom_addr` and `o_sram_waddr` show the current-`cnt` address in every state. They are meaningful only while their strobe is high.
  - `o_sram_wdata` always shows `wdata_r`.
- **Counter:** width `$clog2(copy_words)`, minimum 1 bit. It never wraps, because the exit happens at `copy_words-1`.
- **Reset mid-copy:** `i_nrst=0` at any edge returns the block to the reset state. No partial write completes after that edge. The copy restarts from word 0 once reset is released.
- **Bypass:** `i_bypass` is ignored outside IDLE.

## Timing
- **Reset values:** `o_rom_req=0`, `o_rom_addr=0`, `o_sram_wvalid=0`, `o_sram_waddr=sram_base`, `o_sram_wdata=0`, `o_sram_wstrb=0`, `o_busy=0`, `o_done=0`, `o_cpu_nrst=0`.
- **Edge numbering:** E0 is the first rising edge that samples `i_nrst=1`.
- **Per-word cost:** 3 cycles with no backpressure. Each cycle of `i_sram_wready=0` in WRITE adds 1 cycle.
- **Copy timeline:** DONE is entered at E(3·N) with no backpressure, so `o_done` and `o_cpu_nrst` rise after E(3·N).
  - Example: N=1 gives DONE after E3.
- **Bypass timeline:** DONE is entered at E0.
- **ROM sampling:** `i_rom_rdata` is sampled at the edge that ends WAIT.

## Structure
- **Shared package `bootcopy_pkg`:** holds the `bootcopy_state_t` enum (IDLE, READ, WAIT, WRITE, DONE) and `localparam int BOOTCOPY_WORD_BYTES = 8`.
- **Parameter source:** defaults come from the target config package constants.
- **Sub-modules:** none. The block is a single FSM with a counter and one data register. Instantiate it in the SoC top next to the Boot ROM and the SRAM.

## Test plan
- **Plain copy:** `copy_words=4`, ROM word k = `0xA5A5_0000_0000_0000+k`, `wready=1`.
  - Required: writes to addr 0, 8, 16, 24 with matching data and `wstrb=0xFF`.
  - Required: `o_done` and `o_cpu_nrst` rise after E12.
- **Backpressure:** same setup, `wready=0` for 5 cycles during word 2.
  - Required: `wvalid`, `waddr=16` and `wdata` stable throughout the stall.
  - Required: done after E17, exactly 4 writes.
- **Bypass:** `i_bypass=1` at reset release.
  - Required: no `rom_req`, no `wvalid`, done after E0.
- **Reset mid-copy:** assert `i_nrst=0` during word 2 WRITE for 2 cycles.
  - Required: all outputs at reset values.
  - Required: after release, the first ROM read is addr 0 and 4 full writes follow.
- **Offset and minimum length:** `sram_base=0x100`, `copy_words=1`.
  - Required: single write to 0x100, done after E3, `o_busy` high for exactly 3 cycles.
